otter_cu_fsm: RTL and testbench
===============================

# otter_cu_fsm

Multi-cycle control-unit state machine for the OTTER RV32I core. It sequences each instruction through fetch, execute and write-back, and handles memory wait states, CSR writes, MRET and interrupt entry. It drives the write/read enables of the PC register, register file, memory and CSR file. The combinational decoder independently supplies ALU, mux-select and PC-source controls from the same instruction bits. The block also keeps a retired-instruction counter for the CSR file.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset; one clock, reset is asynchronous and active-high
- INTR  in  1  external interrupt request, level
- MIE  in  1  machine interrupt enable from CSR file
- opcode  in  7  instruction bits [6:0]
- func3  in  3  instruction bits [14:12]
- mem_ack  in  1  data-memory completion for load/store (1 = done this cycle)
- reset  out  1  synchronous clear to PC and register file
- pc_we  out  1  PC register write enable
- rf_we  out  1  register-file write enable
- memRDEN1  out  1  instruction-memory read enable
- memRDEN2  out  1  data-memory read enable
- memWE2  out  1  data-memory write enable
- csr_we  out  1  CSR write enable
- int_taken  out  1  interrupt entry strobe (PC source = mtvec, CSR save)
- mret_exec  out  1  MRET strobe
- illegal  out  1  unknown-opcode strobe
- state  out  3  current state code, debug
- instret  out  CNT_W  retired-instruction count

## Operation
- States and codes: INIT=0, FETCH=1, EXEC=2, WB=3, INTR=4. Unused codes go to INIT.
- Outputs are combinational from state, opcode, func3 and mem_ack. Every output defaults to 0.
- INIT: reset=1 → FETCH.
- FETCH: memRDEN1=1 → EXEC.
- EXEC, by opcode:
  - LOAD 0000011: memRDEN2=1 → WB.
  - STORE 0100011: memWE2=1. While mem_ack=0, stay in EXEC with memWE2 held. When mem_ack=1, pc_we=1 and the instruction completes.
  - BRANCH 1100011: pc_we=1, then complete.
  - SYSTEM 1110011, func3=001 (CSRRW): csr_we=1, rf_we=1, pc_we=1, then complete.
  - SYSTEM 1110011, func3=000 (MRET): mret_exec=1, pc_we=1, then complete. Any other SYSTEM func3 is treated as illegal.
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111: rf_we=1, pc_we=1, then complete.
  - Any other opcode: illegal=1, pc_we=1 (executes as a NOP), then complete.
- WB: memRDEN2=1 held.
  - While mem_ack=0, stay in WB.
  - When mem_ack=1: rf_we=1, pc_we=1, then complete.
- Completion from EXEC or WB:
  - Go to INTR if INTR=1 and MIE=1 and the completing instruction is not MRET.
  - Otherwise go to FETCH.
- INTR: int_taken=1, pc_we=1 → FETCH. The CSR file clears MIE on int_taken; this block does not.
- instret increments by 1 on every completion cycle, including illegal and MRET. It does not increment on INTR cycles. It wraps modulo 2^CNT_W.

## Timing
- RST=1 forces state=INIT and instret=0 immediately, independent of CLK, and aborts any in-flight instruction.
- While RST=1, reset=1 and all other strobes are 0. After RST falls, INIT lasts exactly one cycle.
- Cycle counts with mem_ack=1 on the first cycle it is sampled:
  - Non-memory instruction: 2 cycles (FETCH, EXEC).
  - Load: 3 cycles.
  - Store: 2 cycles.
  - Each cycle of mem_ack=0 adds 1 cycle.
  - Interrupt entry adds 1 cycle.
- mem_ack is ignored in FETCH, INTR and INIT, and for non-memory opcodes in EXEC.
- INTR is sampled only on completion cycles. A pulse that falls before a completion is lost; the requester must hold the level.
- If INTR and MRET coincide, the MRET completes first. The interrupt is re-evaluated at the next completion.
- Every strobe (pc_we, rf_we, csr_we, int_taken, mret_exec, illegal) is high for exactly one cycle per event. memRDEN2 and memWE2 stay high for the whole wait.

## Test plan
- Reset: assert RST mid-WB → state=0 and instret=0 asynchronously. Release RST → reset=1 for 1 cycle, then memRDEN1=1 on the next cycle.
- OP-IMM stream of 4 instructions (opcode 0010011), mem_ack=0 → state alternates 1,2. rf_we=pc_we=1 in each EXEC. instret=4 after 8 cycles.
- Load with mem_ack low for 3 WB cycles → memRDEN2 high for 5 cycles (EXEC + 4 WB). rf_we and pc_we are high only on the 4th WB cycle. instret +1.
- Store with mem_ack on the 2nd EXEC cycle → memWE2 high for 2 cycles. pc_we high on the second cycle only. rf_we stays 0.
- INTR=1, MIE=1 during an ADD → EXEC is followed by INTR (int_taken=pc_we=1), then FETCH. Same with MIE=0 → goes directly to FETCH.
- MRET with INTR=1, MIE=1 → mret_exec=1, next state FETCH. Opcode 1111111 → illegal=1, pc_we=1, rf_we=0.

Source files
------------

// File: rtl/otter_cu_fsm.sv
// OTTER RV32I multi-cycle control unit: sequences fetch / execute / write-back,
// memory waits, CSR writes, MRET and interrupt entry, and counts retired instructions.
module otter_cu_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INTR,
  input  logic             MIE,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic             mem_ack,
  output logic             reset,
  output logic             pc_we,
  output logic             rf_we,
  output logic             memRDEN1,
  output logic             memRDEN2,
  output logic             memWE2,
  output logic             csr_we,
  output logic             int_taken,
  output logic             mret_exec,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_INTR  = 3'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             done;
  logic             is_mret;

  always_comb begin
    reset     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    memWE2    = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    illegal   = 1'b0;
    done      = 1'b0;
    is_mret   = 1'b0;
    state_d   = ST_INIT;
    case (state_q)
      ST_INIT: begin
        reset   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        memRDEN1 = 1'b1;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode)
          OP_LOAD: begin
            memRDEN2 = 1'b1;
            state_d  = ST_WB;
          end
          OP_STORE: begin
            // Write enable stays up for the whole wait; pc advances only on ack.
            memWE2 = 1'b1;
            if (mem_ack) begin
              pc_we = 1'b1;
              done  = 1'b1;
            end else begin
              state_d = ST_EXEC;
            end
          end
          OP_BRANCH: begin
            pc_we = 1'b1;
            done  = 1'b1;
          end
          OP_SYSTEM: begin
            pc_we = 1'b1;
            done  = 1'b1;
            if (func3 == 3'b001) begin
              csr_we = 1'b1;
              rf_we  = 1'b1;
            end else if (func3 == 3'b000) begin
              mret_exec = 1'b1;
              is_mret   = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
          OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            rf_we = 1'b1;
            pc_we = 1'b1;
            done  = 1'b1;
          end
          default: begin
            illegal = 1'b1;
            pc_we   = 1'b1;
            done    = 1'b1;
          end
        endcase
      end
      ST_WB: begin
        memRDEN2 = 1'b1;
        if (mem_ack) begin
          rf_we = 1'b1;
          pc_we = 1'b1;
          done  = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_INTR: begin
        int_taken = 1'b1;
        pc_we     = 1'b1;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase
    // Interrupts are only taken between instructions, and never right after MRET.
    if (done) state_d = (INTR && MIE && !is_mret) ? ST_INTR : ST_FETCH;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_INIT;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (done) instret_q <= instret_q + CNT_ONE;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Bench for otter_cu_fsm: each instruction is expanded into its expected per-cycle
// control trace from the instruction class, then replayed against the DUT.
module tb_otter_cu_fsm;
  localparam int CNT_W = 32;
  localparam int EW    = CNT_W + 13;

  // ctrl vector order: reset pc_we rf_we memRDEN1 memRDEN2 memWE2 csr_we int_taken mret_exec illegal
  localparam logic [9:0] O_RESET = 10'h200;
  localparam logic [9:0] O_PC    = 10'h100;
  localparam logic [9:0] O_RF    = 10'h080;
  localparam logic [9:0] O_RD1   = 10'h040;
  localparam logic [9:0] O_RD2   = 10'h020;
  localparam logic [9:0] O_WE2   = 10'h010;
  localparam logic [9:0] O_CSR   = 10'h008;
  localparam logic [9:0] O_INT   = 10'h004;
  localparam logic [9:0] O_MRET  = 10'h002;
  localparam logic [9:0] O_ILL   = 10'h001;

  logic CLK = 1'b0;
  logic RST, INTR, MIE, mem_ack;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic reset, pc_we, rf_we, memRDEN1, memRDEN2, memWE2, csr_we, int_taken, mret_exec, illegal;
  logic [2:0] state;
  logic [CNT_W-1:0] instret;
  logic [9:0] ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0]    exp_q[$];
  logic [12:0]      stim_q[$];
  logic [CNT_W-1:0] model_cnt;

  logic [6:0] op_tab [13] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011, 7'b0110011,
                              7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                              7'b1111111, 7'b0000000, 7'b0001111};

  otter_cu_fsm #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .INTR(INTR), .MIE(MIE), .opcode(opcode), .func3(func3),
    .mem_ack(mem_ack), .reset(reset), .pc_we(pc_we), .rf_we(rf_we), .memRDEN1(memRDEN1),
    .memRDEN2(memRDEN2), .memWE2(memWE2), .csr_we(csr_we), .int_taken(int_taken),
    .mret_exec(mret_exec), .illegal(illegal), .state(state), .instret(instret)
  );

  assign ctrl = {reset, pc_we, rf_we, memRDEN1, memRDEN2, memWE2, csr_we, int_taken, mret_exec, illegal};

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [6:0] op, input logic [2:0] f3, input logic ack,
                      input logic intr, input logic mie, input logic [2:0] st, input logic [9:0] o);
    stim_q.push_back({op, f3, ack, intr, mie});
    exp_q.push_back({model_cnt, st, o});
  endtask

  // Expected trace of one instruction, derived from its class and the wait count.
  task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input int nwait,
                             input logic intr, input logic mie);
    logic       mret;
    logic [9:0] o;
    mret = 1'b0;
    push(op, f3, rbit(), rbit(), rbit(), 3'd1, O_RD1);
    if (op == 7'b0000011) begin
      push(op, f3, rbit(), rbit(), rbit(), 3'd2, O_RD2);
      for (int i = 0; i < nwait; i++) push(op, f3, 1'b0, rbit(), rbit(), 3'd3, O_RD2);
      push(op, f3, 1'b1, intr, mie, 3'd3, O_RD2 | O_RF | O_PC);
    end else if (op == 7'b0100011) begin
      for (int i = 0; i < nwait; i++) push(op, f3, 1'b0, rbit(), rbit(), 3'd2, O_WE2);
      push(op, f3, 1'b1, intr, mie, 3'd2, O_WE2 | O_PC);
    end else begin
      case (op)
        7'b1100011: o = O_PC;
        7'b1110011: begin
          if (f3 == 3'b001) o = O_CSR | O_RF | O_PC;
          else if (f3 == 3'b000) begin
            o = O_MRET | O_PC;
            mret = 1'b1;
          end else o = O_ILL | O_PC;
        end
        7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: o = O_RF | O_PC;
        default: o = O_ILL | O_PC;
      endcase
      push(op, f3, rbit(), intr, mie, 3'd2, o);
    end
    model_cnt = model_cnt + 1;
    if (intr && mie && !mret) push(op, f3, rbit(), rbit(), rbit(), 3'd4, O_INT | O_PC);
  endtask

  task automatic run_q();
    logic [12:0]   s;
    logic [EW-1:0] e;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      {opcode, func3, mem_ack, INTR, MIE} = s;
      @(negedge CLK);
      check("state", 64'(state), 64'(e[12:10]));
      check("ctrl", 64'(ctrl), 64'(e[9:0]));
      check("instret", 64'(instret), 64'(e[EW-1:13]));
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_in_reset();
    check("rst_state", 64'(state), 64'(3'd0));
    check("rst_instret", 64'(instret), 64'(0));
    check("rst_ctrl", 64'(ctrl), 64'(O_RESET));
  endtask

  initial begin
    RST = 1'b1; INTR = 1'b0; MIE = 1'b0; mem_ack = 1'b0; opcode = '0; func3 = '0;
    model_cnt = '0;
    #3;
    check_in_reset();
    @(posedge CLK);
    #1 RST = 1'b0;
    push(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, O_RESET);

    // OP-IMM stream, then load with 3 waits, store with 1 wait
    for (int i = 0; i < 4; i++) model_instr(7'b0010011, 3'd0, 0, 1'b0, 1'b0);
    model_instr(7'b0000011, 3'd2, 3, 1'b0, 1'b0);
    model_instr(7'b0100011, 3'd2, 1, 1'b0, 1'b0);
    // ADD with interrupt enabled / masked, MRET under pending interrupt, illegal opcode
    model_instr(7'b0110011, 3'd0, 0, 1'b1, 1'b1);
    model_instr(7'b0110011, 3'd0, 0, 1'b1, 1'b0);
    model_instr(7'b1110011, 3'd0, 0, 1'b1, 1'b1);
    model_instr(7'b1111111, 3'd0, 0, 1'b0, 1'b0);
    model_instr(7'b1110011, 3'd1, 0, 1'b1, 1'b1);
    model_instr(7'b1100011, 3'd0, 0, 1'b0, 1'b1);
    run_q();

    // Reset asserted asynchronously in the middle of a load wait
    stim_q.push_back({7'b0000011, 3'd0, 1'b0, 1'b0, 1'b0});
    exp_q.push_back({model_cnt, 3'd1, O_RD1});
    push(7'b0000011, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, O_RD2);
    push(7'b0000011, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3, O_RD2);
    run_q();
    mem_ack = 1'b0;
    #2 RST = 1'b1;
    #1;
    check_in_reset();
    @(posedge CLK);
    #1 RST = 1'b0;
    model_cnt = '0;
    push(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, O_RESET);

    for (int i = 0; i < 80; i++) begin
      logic [6:0] op;
      logic [2:0] f3;
      op = op_tab[$urandom_range(0, 12)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
      f3 = 3'($urandom_range(0, 7));
      if (op == 7'b1110011 && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
      model_instr(op, f3, int'($urandom_range(0, 3)), rbit(), rbit());
    end
    run_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
